uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Byte FIFO and transmit sequencer placed directly upstream of `uart`'s transmitter. Accepts bytes from a producer (CPU/bus bridge, pattern generator) at up to one per clock. Buffers them, and hands them one at a time to `uart` over its `tx_data_valid`/`tx_data`/`tx_busy` handshake, so producers never have to poll `tx_busy` themselves.

## Interface
Parameters:
- `DEPTH`, 16: FIFO capacity in bytes; power of two, ≥ 2.
- `ACCEPT_TIMEOUT`, 16: cycles to wait for `tx_busy` to rise after a handoff before giving up; ≥ 2.

Ports:
- `clk` in 1: single clock, shared with `uart`.
- `rst` in 1: synchronous, active-high reset.
- `wr_en` in 1: write strobe; `wr_data` is sampled on the rising edge while high.
- `wr_data` in 8: byte to enqueue.
- `full` out 1: FIFO holds `DEPTH` bytes.
- `empty` out 1: FIFO holds 0 bytes.
- `level` out `$clog2(DEPTH)+1`: current occupancy, 0..`DEPTH`.
- `tx_busy` in 1: from `uart`.
- `tx_data_valid` out 1: one-cycle handoff strobe to `uart`.
- `tx_data` out 8: byte to `uart`; stable from the strobe cycle until the next strobe.
- `overflow` out 1: sticky write-while-full flag. Present only with `UART_TX_FIFO_OVF_EN`.

## Operation
- Storage: `DEPTH`×8 register array. Read and write pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`.
- `level` is a registered counter:
  - +1 on an accepted write.
  - −1 on a pop.
  - Unchanged when a write and a pop happen in the same cycle.
- `full` = (`level`==`DEPTH`); `empty` = (`level`==0). Both are decoded from the registered `level`.
- Write acceptance: `wr_en && !full`, where `full` is the registered value. A write while full is dropped, even if a pop occurs in the same cycle.
- Sequencer FSM:
  - IDLE: if `!empty && !tx_busy`, load `tx_data` ← head byte, pulse `tx_data_valid`, pop, go to WAIT_ACCEPT.
  - WAIT_ACCEPT:
    - If `tx_busy`==1, go to WAIT_DONE.
    - Otherwise increment the timeout counter. When it reaches `ACCEPT_TIMEOUT`−1, go to IDLE. The byte counts as consumed; there is no retry.
  - WAIT_DONE: when `tx_busy`==0, go to IDLE.
- At most one byte is in flight at a time. Bytes leave in write order.

## Timing
- Reset values:
  - `tx_data_valid`=0, `tx_data`=8'h00.
  - `level`=0, `empty`=1, `full`=0.
  - pointers 0, FSM=IDLE, timeout counter 0.
  - `overflow`=0.
- Write latency: a write sampled at edge k is reflected in `level`, `empty` and `full` after edge k.
- Handoff latency: first byte into an empty FIFO with `tx_busy`=0, written at edge k.
  - `tx_data_valid`=1 during the cycle after edge k+1.
  - The pop takes effect at edge k+2.
- `tx_data_valid` is high for exactly one cycle per byte and is never asserted outside IDLE→WAIT_ACCEPT.
- Minimum spacing between strobes is 3 cycles (IDLE, WAIT_ACCEPT, WAIT_DONE, each ≥ 1 cycle). The real spacing is set by the `uart` frame length.
- `tx_busy` high while in IDLE (line owned elsewhere, or still finishing): the sequencer holds in IDLE and the FIFO keeps accepting writes.
- Pointer wrap: index `DEPTH`−1 is followed by index 0. Order and `level` stay correct across the wrap.
- `rst` mid-frame: everything listed under reset values is restored on the next edge. A byte already handed to `uart` is not recalled; its transmission is outside this block.

## Configuration
- `UART_TX_FIFO_OVF_EN` defined:
  - `overflow` port exists.
  - `overflow` sets on any cycle with `wr_en && full`.
  - It is sticky until `rst`.
- Not defined:
  - No `overflow` port and no flag register.
  - Writes while full are silently dropped.
- FIFO and FSM behaviour is otherwise identical.

## Test plan
- Reset and first byte:
  - After `rst`, write 8'hA5 once with `tx_busy` held 0.
  - Required: `level` goes 0→1→0, `tx_data_valid` pulses 1 cycle, `tx_data`=8'hA5 two cycles after the write.
- Burst ordering with `uart` bound:
  - Write 8'h00, 8'hFF and 10 random bytes back to back into `uart`, with `sout` looped to `sin`.
  - Required: `rx_data` sequence equals the written sequence, and exactly 12 `tx_data_valid` pulses.
- Full, overflow and wrap:
  - Hold `tx_busy`=1.
  - Write `DEPTH`+2 bytes. Required: `full`=1, `level`=`DEPTH`, last 2 bytes dropped, `overflow`=1 when `UART_TX_FIFO_OVF_EN` is defined.
  - Release `tx_busy`, then write 4 more bytes. Required: all bytes go out in order across the pointer wrap.
- Accept timeout:
  - Keep `tx_busy`=0 permanently and write 2 bytes.
  - Required: strobes exactly `ACCEPT_TIMEOUT`+1 cycles apart (WAIT_ACCEPT for `ACCEPT_TIMEOUT` cycles plus 1 IDLE cycle), and `level` ends at 0.
- Reset mid-operation:
  - Fill 5 bytes, then assert `rst` while in WAIT_DONE.
  - Required: next cycle `level`=0, `tx_data_valid`=0, FSM in IDLE, and no further strobes until a new write.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// Byte FIFO plus a small sequencer that feeds the uart transmitter through its
// tx_data_valid / tx_data / tx_busy handshake. Producers push bytes at up to
// one per clock and never have to look at tx_busy themselves.
//
// Parameters
//   DEPTH          FIFO capacity in bytes (power of two, >= 2)
//   ACCEPT_TIMEOUT cycles to wait for tx_busy after a handoff (>= 2)
//
// Ports
//   clk            single clock, shared with uart
//   rst            synchronous active-high reset
//   wr_en, wr_data write strobe and byte to enqueue
//   full, empty    decoded from the registered level
//   level          occupancy, 0..DEPTH
//   tx_busy        from uart
//   tx_data_valid  one-cycle handoff strobe to uart
//   tx_data        byte to uart, held until the next strobe
//   overflow       sticky write-while-full flag (only with UART_TX_FIFO_OVF_EN)
//
// Build option
//   UART_TX_FIFO_OVF_EN  adds the overflow port and its flag register.
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DEPTH          = 16,
    parameter int ACCEPT_TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    input  logic                     tx_busy,
    output logic                     tx_data_valid,
    output logic [7:0]               tx_data
`ifdef UART_TX_FIFO_OVF_EN
    ,
    output logic                     overflow
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(ACCEPT_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACCEPT,
        WAIT_DONE
    } state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level_q;

    state_t        state;
    state_t        state_next;
    logic [TW-1:0] to_cnt;
    logic [TW-1:0] to_cnt_next;
    logic          load;

    logic          wr_accept;
    logic          pop;

    assign level = level_q;
    assign full  = (level_q == (AW+1)'(DEPTH));
    assign empty = (level_q == '0);

    // A write while full is dropped even if a pop happens in the same cycle.
    assign wr_accept = wr_en && !full;
    // The head byte is popped in the cycle the strobe is visible, i.e. one
    // edge after it was copied into tx_data.
    assign pop = tx_data_valid;

    // NOTE: the storage array carries no reset; only pointers and level define
    // which entries are meaningful, and leaving it unreset keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the values from before the edge, regardless of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_accept, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Sequencer next-state logic.
    // NOTE: every output of this block is given a default first so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next  = state;
        to_cnt_next = to_cnt;
        load        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !tx_busy) begin
                    load       = 1'b1;
                    state_next = WAIT_ACCEPT;
                end
            end
            WAIT_ACCEPT: begin
                if (tx_busy) begin
                    state_next  = WAIT_DONE;
                    to_cnt_next = '0;
                end else if (to_cnt == TW'(ACCEPT_TIMEOUT - 1)) begin
                    // uart never took the byte; it is still counted as sent.
                    state_next  = IDLE;
                    to_cnt_next = '0;
                end else begin
                    to_cnt_next = to_cnt + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next  = IDLE;
                to_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            to_cnt        <= '0;
            tx_data_valid <= 1'b0;
            tx_data       <= 8'h00;
        end else begin
            state         <= state_next;
            to_cnt        <= to_cnt_next;
            tx_data_valid <= load;
            if (load) begin
                tx_data <= mem[rd_ptr];
            end
        end
    end

`ifdef UART_TX_FIFO_OVF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (wr_en && full) begin
            overflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Self-checking bench for uart_tx_fifo: a cycle-by-cycle vector table covering
// reset, first handoff and write/pop overlap, followed by hand-written
// sequences for burst ordering against a simple uart busy model, full/overflow
// with pointer wrap, accept timeout and reset in WAIT_DONE.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 16;
    localparam int FRAME   = 5;
    localparam int LW      = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full;
    logic          empty;
    logic [LW-1:0] level;
    logic          tx_busy;
    logic          tx_data_valid;
    logic [7:0]    tx_data;
`ifdef UART_TX_FIFO_OVF_EN
    logic          overflow;
`endif

    logic busy_manual = 1'b0;
    logic busy_model  = 1'b0;
    logic model_en    = 1'b0;
    assign tx_busy = model_en ? busy_model : busy_manual;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] cap_data[$];
    int         cap_cyc[$];

    uart_tx_fifo #(
        .DEPTH          (DEPTH),
        .ACCEPT_TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .full          (full),
        .empty         (empty),
        .level         (level),
        .tx_busy       (tx_busy),
        .tx_data_valid (tx_data_valid),
        .tx_data       (tx_data)
`ifdef UART_TX_FIFO_OVF_EN
        ,
        .overflow      (overflow)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor: records every handed-off byte and the cycle it was seen.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_data_valid) begin
                cap_data.push_back(tx_data);
                cap_cyc.push_back(cyc);
            end
        end
    end

    // uart stand-in: raises busy right after a strobe and holds it for FRAME cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (model_en && tx_data_valid) begin
                busy_model = 1'b1;
                repeat (FRAME) @(negedge clk);
                busy_model = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic wait_pulses(input int target, input int budget, input string name);
        int n = 0;
        while (cap_data.size() < target && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        check(name, cap_data.size(), target);
    endtask

    typedef struct {
        logic          wr_en;
        logic [7:0]    wr_data;
        logic          busy;
        logic [LW-1:0] level;
        logic          empty;
        logic          full;
        logic          valid;
        logic [7:0]    data;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int base;
        logic [7:0] exp_bytes[$];

        //            wr   data   busy  level  emp   full  vld   tx_data
        vecs[0]  = '{1'b1, 8'hA5, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1, 8'hA5};
        vecs[2]  = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 8'hA5};
        vecs[3]  = '{1'b1, 8'h3C, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 8'hA5};
        vecs[4]  = '{1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 8'hA5};
        vecs[5]  = '{1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1, 8'h3C};
        vecs[6]  = '{1'b1, 8'h77, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 8'h3C};
        vecs[7]  = '{1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 8'h3C};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1, 8'h77};
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 8'h77};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 8'h77};

        // ---------------- reset ----------------
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        repeat (2) step();
        check("rst_level", level, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_valid", tx_data_valid, 0);
        check("rst_data", tx_data, 8'h00);
`ifdef UART_TX_FIFO_OVF_EN
        check("rst_overflow", overflow, 0);
`endif
        rst = 1'b0;

        // ---------------- vector table ----------------
        for (int i = 0; i < 11; i++) begin
            wr_en       = vecs[i].wr_en;
            wr_data     = vecs[i].wr_data;
            busy_manual = vecs[i].busy;
            step();
            check($sformatf("vec%0d_level", i), level, vecs[i].level);
            check($sformatf("vec%0d_empty", i), empty, vecs[i].empty);
            check($sformatf("vec%0d_full", i), full, vecs[i].full);
            check($sformatf("vec%0d_valid", i), tx_data_valid, vecs[i].valid);
            check($sformatf("vec%0d_data", i), tx_data, vecs[i].data);
        end
        wr_en       = 1'b0;
        busy_manual = 1'b0;

        // ---------------- burst ordering with uart model ----------------
        model_en = 1'b1;
        base     = cap_data.size();
        exp_bytes.push_back(8'h00);
        exp_bytes.push_back(8'hFF);
        for (int i = 0; i < 10; i++) exp_bytes.push_back(8'($urandom_range(0, 255)));
        foreach (exp_bytes[i]) write_byte(exp_bytes[i]);
        wait_pulses(base + 12, 400, "burst_pulses");
        repeat (20) step();
        check("burst_exact_count", cap_data.size(), base + 12);
        for (int i = 0; i < 12; i++) begin
            if (base + i < cap_data.size())
                check($sformatf("burst_byte%0d", i), cap_data[base + i], exp_bytes[i]);
        end
        check("burst_level_end", level, 0);

        // ---------------- full, overflow and pointer wrap ----------------
        model_en    = 1'b0;
        busy_manual = 1'b1;
        base        = cap_data.size();
        for (int i = 0; i < DEPTH + 2; i++) write_byte(8'h40 + 8'(i));
        step();
        check("full_level", level, DEPTH);
        check("full_flag", full, 1);
        check("full_empty", empty, 0);
        check("full_no_strobe", cap_data.size(), base);
`ifdef UART_TX_FIFO_OVF_EN
        check("full_overflow", overflow, 1);
`endif
        model_en = 1'b1;
        begin
            int n = 0;
            while (level > LW'(DEPTH - 4) && n < 200) begin
                step();
                n++;
            end
            check("wrap_drain", (level <= LW'(DEPTH - 4)), 1);
        end
        for (int i = 0; i < 4; i++) write_byte(8'h80 + 8'(i));
        wait_pulses(base + DEPTH + 4, 600, "wrap_pulses");
        repeat (20) step();
        check("wrap_exact_count", cap_data.size(), base + DEPTH + 4);
        for (int i = 0; i < DEPTH + 4; i++) begin
            if (base + i < cap_data.size())
                check($sformatf("wrap_byte%0d", i), cap_data[base + i],
                      (i < DEPTH) ? 32'(8'h40 + 8'(i)) : 32'(8'h80 + 8'(i - DEPTH)));
        end
        check("wrap_level_end", level, 0);
`ifdef UART_TX_FIFO_OVF_EN
        check("overflow_sticky", overflow, 1);
`endif

        // ---------------- accept timeout ----------------
        model_en    = 1'b0;
        busy_manual = 1'b0;
        base        = cap_data.size();
        write_byte(8'hD1);
        write_byte(8'hD2);
        wait_pulses(base + 2, 3 * TIMEOUT + 10, "timeout_pulses");
        if (cap_cyc.size() >= base + 2) begin
            check("timeout_spacing", cap_cyc[base + 1] - cap_cyc[base], TIMEOUT + 1);
            check("timeout_byte0", cap_data[base], 8'hD1);
            check("timeout_byte1", cap_data[base + 1], 8'hD2);
        end
        repeat (TIMEOUT + 4) step();
        check("timeout_level_end", level, 0);
        check("timeout_empty_end", empty, 1);
        check("timeout_exact_count", cap_data.size(), base + 2);

        // ---------------- reset while in WAIT_DONE ----------------
        model_en = 1'b1;
        base     = cap_data.size();
        for (int i = 0; i < 5; i++) write_byte(8'hC0 + 8'(i));
        wait_pulses(base + 1, 50, "midrst_first_strobe");
        // The model raised busy during the strobe cycle, so the sequencer is
        // now in WAIT_DONE with four bytes still queued.
        check("midrst_level_before", level, 4);
        rst = 1'b1;
        step();
        check("midrst_level", level, 0);
        check("midrst_empty", empty, 1);
        check("midrst_valid", tx_data_valid, 0);
        check("midrst_data", tx_data, 8'h00);
        rst         = 1'b0;
        model_en    = 1'b0;
        busy_manual = 1'b0;
        base        = cap_data.size();
        repeat (20) step();
        check("midrst_no_strobe", cap_data.size(), base);
        write_byte(8'hE7);
        check("midrst_idle_wait", tx_data_valid, 0);
        step();
        check("midrst_idle_valid", tx_data_valid, 1);
        check("midrst_idle_data", tx_data, 8'hE7);
        step();
        check("midrst_idle_pulse_end", tx_data_valid, 0);
        check("midrst_idle_level", level, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
